// File: rtl/prog_run_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// prog_seq_pkg
// Shared types and sizing helpers for the program run sequencer.
//   seq_state_t   : sequencer FSM states
//   progIdxWidth  : width of a program index for a given program count (min 1)
//   PW            : program index width for the default configuration
// ---------------------------------------------------------------------------
package prog_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } seq_state_t;

  // A single program still needs a one-bit index port.
  function automatic int progIdxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_PROGS = 3;
  localparam int PW            = progIdxWidth(DEF_NUM_PROGS);

endpackage

// File: rtl/prog_run_sequencer_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Up-counter used by the sequencer to time the START and RUN phases.
//   i_clk      : clock, posedge
//   i_rst      : asynchronous reset, active high
//   i_clr      : synchronous clear to zero (wins over i_en)
//   i_en       : count this cycle
//   i_limit    : phase length in cycles
//   o_count    : cycles counted so far in this phase (excluding the current one)
//   o_atLimit  : high while enabled in the cycle that is the i_limit-th one
// ---------------------------------------------------------------------------
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_atLimit
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_countPlusOne;

  assign w_countPlusOne = r_count + W'(1);
  // Counting the current cycle as well, so the flag rises on the last cycle
  // of the phase rather than one cycle after it.
  assign o_atLimit      = i_en && (w_countPlusOne == i_limit);
  assign o_count        = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_countPlusOne;
    end
  end

endmodule

// File: rtl/prog_run_sequencer.sv
// ---------------------------------------------------------------------------
// prog_run_sequencer
// Upstream run controller for the core: on Go it starts programs
// 0..NUM_PROGS-1 back to back, pulsing the core Start for START_CYCLES
// cycles, waiting for the core Ack, recording each program's RUN-cycle count
// and aborting the run when a program exceeds TIMEOUT RUN cycles.
//   i_clk       : clock, posedge
//   i_rst       : asynchronous reset, active high
//   i_go        : run request, level-sampled in IDLE only
//   i_coreAck   : core done flag, only honoured in RUN
//   o_coreStart : core Start input
//   o_progIdx   : index of the current / last program
//   o_progDone  : one-cycle pulse after a program is acked
//   o_cycleCnt  : RUN-cycle count of the last acked program
//   o_busy      : high in START or RUN
//   o_done      : one-cycle pulse when a run finishes or aborts
//   o_timedOut  : sticky, last run aborted on timeout
// ---------------------------------------------------------------------------
module prog_run_sequencer
  import prog_seq_pkg::*;
#(
  parameter int               NUM_PROGS    = 3,
  parameter int               START_CYCLES = 2,
  parameter int               CYC_W        = 16,
  parameter logic [CYC_W-1:0] TIMEOUT      = CYC_W'(4000),
  localparam int              IDX_W        = progIdxWidth(NUM_PROGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic             i_coreAck,
  output logic             o_coreStart,
  output logic [IDX_W-1:0] o_progIdx,
  output logic             o_progDone,
  output logic [CYC_W-1:0] o_cycleCnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timedOut
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic             r_coreStart;
  logic [IDX_W-1:0] r_progIdx;
  logic             r_progDone;
  logic [CYC_W-1:0] r_cycleCnt;
  logic             r_busy;
  logic             r_done;
  logic             r_timedOut;

  logic             w_startAtLimit;
  logic [CYC_W-1:0] w_unusedStartCount;
  logic             w_runAtLimit;
  logic [CYC_W-1:0] w_runCount;
  logic [CYC_W-1:0] w_runCountNow;
  logic             w_ackNow;
  logic             w_timeoutNow;
  logic             w_goNow;

  // Each timer is held at zero outside its own phase, so entering the phase
  // always starts a fresh count.
  cycle_timer #(.W(CYC_W)) u_startTimer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (r_state != S_START),
    .i_en      (r_state == S_START),
    .i_limit   (CYC_W'(START_CYCLES)),
    .o_count   (w_unusedStartCount),
    .o_atLimit (w_startAtLimit)
  );

  cycle_timer #(.W(CYC_W)) u_runTimer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (r_state != S_RUN),
    .i_en      (r_state == S_RUN),
    .i_limit   (TIMEOUT),
    .o_count   (w_runCount),
    .o_atLimit (w_runAtLimit)
  );

  // The reported count includes the cycle in which Ack arrives.
  assign w_runCountNow = w_runCount + CYC_W'(1);
  assign w_goNow       = (r_state == S_IDLE) && i_go;
  assign w_ackNow      = (r_state == S_RUN) && i_coreAck;
  // Ack beats the timeout when both land on the same cycle.
  assign w_timeoutNow  = (r_state == S_RUN) && !i_coreAck && w_runAtLimit;

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:  if (i_go) w_nextState = S_START;
      S_START: if (w_startAtLimit) w_nextState = S_RUN;
      S_RUN: begin
        if (i_coreAck) begin
          w_nextState = (r_progIdx == LAST_IDX) ? S_DONE : S_START;
        end else if (w_runAtLimit) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_coreStart <= 1'b0;
      r_progIdx   <= '0;
      r_progDone  <= 1'b0;
      r_cycleCnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timedOut  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_coreStart <= (w_nextState == S_START);
      r_busy      <= (w_nextState == S_START) || (w_nextState == S_RUN);
      r_done      <= (w_nextState == S_DONE);
      r_progDone  <= w_ackNow;
      if (w_goNow) begin
        r_progIdx  <= '0;
        r_timedOut <= 1'b0;
      end
      if (w_ackNow) begin
        r_cycleCnt <= w_runCountNow;
        if (r_progIdx != LAST_IDX) begin
          r_progIdx <= r_progIdx + IDX_W'(1);
        end
      end
      if (w_timeoutNow) begin
        r_timedOut <= 1'b1;
      end
    end
  end

  assign o_coreStart = r_coreStart;
  assign o_progIdx   = r_progIdx;
  assign o_progDone  = r_progDone;
  assign o_cycleCnt  = r_cycleCnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_timedOut  = r_timedOut;

endmodule
